// File: rtl/sha256_sigma_unit.sv
// rtl/sha256_sigma_unit.sv - registered SHA-256 sigma functions (optional lower sigma1 via SHA_SIGMA_LOWER1_EN)
module sha256_sigma_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] x,
    output logic [31:0] function1,
    output logic [31:0] function2,
`ifdef SHA_SIGMA_LOWER1_EN
    output logic [31:0] function3,
    output logic [31:0] function4
`else
    output logic [31:0] function3
`endif
);

    // Fixed rotations are pure rewiring; only the XOR tree costs logic.
    logic [31:0] sig0_upper_d;
    logic [31:0] sig1_upper_d;
    logic [31:0] sig0_lower_d;

    logic [31:0] function1_q;
    logic [31:0] function2_q;
    logic [31:0] function3_q;

    // Big Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
    assign sig0_upper_d = {x[1:0],  x[31:2]}
                        ^ {x[12:0], x[31:13]}
                        ^ {x[21:0], x[31:22]};

    // Big Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
    assign sig1_upper_d = {x[5:0],  x[31:6]}
                        ^ {x[10:0], x[31:11]}
                        ^ {x[24:0], x[31:25]};

    // Small sigma0: ROTR7 ^ ROTR18 ^ SHR3 (shift zero-fills the top bits)
    assign sig0_lower_d = {x[6:0],  x[31:7]}
                        ^ {x[17:0], x[31:18]}
                        ^ {3'b000,  x[31:3]};

    // Output registers: reset beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            function1_q <= 32'h0000_0000;
            function2_q <= 32'h0000_0000;
            function3_q <= 32'h0000_0000;
        end else if (en) begin
            function1_q <= sig0_upper_d;
            function2_q <= sig1_upper_d;
            function3_q <= sig0_lower_d;
        end
    end

    assign function1 = function1_q;
    assign function2 = function2_q;
    assign function3 = function3_q;

`ifdef SHA_SIGMA_LOWER1_EN
    logic [31:0] sig1_lower_d;
    logic [31:0] function4_q;

    // Small sigma1: ROTR17 ^ ROTR19 ^ SHR10
    assign sig1_lower_d = {x[16:0], x[31:17]}
                        ^ {x[18:0], x[31:19]}
                        ^ {10'b0,   x[31:10]};

    // Same reset/enable behaviour as the other three outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            function4_q <= 32'h0000_0000;
        end else if (en) begin
            function4_q <= sig1_lower_d;
        end
    end

    assign function4 = function4_q;
`endif

endmodule

// File: tb/tb_sha256_sigma_unit.sv
// tb/tb_sha256_sigma_unit.sv - scoreboard bench for sha256_sigma_unit with directed vectors
module tb_sha256_sigma_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] x;
    logic [31:0] function1;
    logic [31:0] function2;
    logic [31:0] function3;
`ifdef SHA_SIGMA_LOWER1_EN
    logic [31:0] function4;
`endif

    sha256_sigma_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .function1 (function1),
        .function2 (function2),
`ifdef SHA_SIGMA_LOWER1_EN
        .function3 (function3),
        .function4 (function4)
`else
        .function3 (function3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] f1;
        logic [31:0] f2;
        logic [31:0] f3;
        logic [31:0] f4;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int passed;
    int failed;
    bit stim_done;

    localparam int NVEC = 15;
    logic        v_rst [NVEC];
    logic        v_en  [NVEC];
    logic [31:0] v_x   [NVEC];
    logic [31:0] v_f1  [NVEC];
    logic [31:0] v_f2  [NVEC];
    logic [31:0] v_f3  [NVEC];
    logic [31:0] v_f4  [NVEC];

    task automatic set_vec(input int i, input logic r, input logic e, input logic [31:0] xv,
                           input logic [31:0] f1, input logic [31:0] f2,
                           input logic [31:0] f3, input logic [31:0] f4);
        v_rst[i] = r;
        v_en[i]  = e;
        v_x[i]   = xv;
        v_f1[i]  = f1;
        v_f2[i]  = f2;
        v_f3[i]  = f3;
        v_f4[i]  = f4;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            failed++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Stimulus: drive on negedge and push the value expected after the next rising edge.
    initial begin
        exp_t e;
        rst = 1'b1;
        en  = 1'b0;
        x   = 32'h0;
        checks = 0;
        passed = 0;
        failed = 0;
        stim_done = 1'b0;
        //        i   rst   en    x              f1             f2             f3             f4
        set_vec(0,  1'b1, 1'b1, 32'h0000_3FFF, 32'h0,         32'h0,         32'h0,         32'h0);
        set_vec(1,  1'b1, 1'b1, 32'h0000_3FFF, 32'h0,         32'h0,         32'h0,         32'h0);
        set_vec(2,  1'b0, 1'b1, 32'h0000_3FFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(3,  1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         32'h0);
        set_vec(4,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 32'h003F_FFFF);
        set_vec(5,  1'b0, 1'b1, 32'h0000_3FFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(6,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(7,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(8,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(9,  1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'h0);
        set_vec(10, 1'b0, 1'b1, 32'h0000_3FFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(11, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         32'h0);
        set_vec(12, 1'b0, 1'b1, 32'h0000_3FFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(13, 1'b0, 1'b0, 32'h0000_0000, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F);
        set_vec(14, 1'b1, 1'b0, 32'h0000_3FFF, 32'h0,         32'h0,         32'h0,         32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = v_rst[i];
            en  = v_en[i];
            x   = v_x[i];
            e.idx = i;
            e.f1  = v_f1[i];
            e.f2  = v_f2[i];
            e.f3  = v_f3[i];
            e.f4  = v_f4[i];
            exp_q.push_back(e);
        end
        @(negedge clk);
        en = 1'b0;
        stim_done = 1'b1;
    end

    // Monitor: outputs are registers, so every rising edge presents one result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("function1", e.idx, function1, e.f1);
                check("function2", e.idx, function2, e.f2);
                check("function3", e.idx, function3, e.f3);
`ifdef SHA_SIGMA_LOWER1_EN
                check("function4", e.idx, function4, e.f4);
`endif
            end
        end
    end

    // Completion: bounded drain of the scoreboard, then summary.
    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0 || !stim_done) begin
            checks++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        if (checks < NVEC * 3) begin
            checks++;
            failed++;
            $display("FAIL count: %0d checks made, expected at least %0d", checks - 1, NVEC * 3);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sha256_sigma_unit.md
# sha256_sigma_unit

Registered SHA-256 sigma-function unit evaluating the three single-operand bit-mixing functions used by the compression and message-schedule datapath: Function1 (Σ0), Function2 (Σ1) and Function3 (σ0). All functions take the same 32-bit word and produce results in parallel, registered on one clock with enable-gated update. It sits between the working-variable / message-schedule registers and the temporary-word adders of the hashing core.

## Interface
Parameters:
- none; word width fixed at 32 bits.

Ports:
- clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable; when low, all outputs hold.
- x  input  32  operand word.
- function1  output  32  registered Σ0(x) = ROTR2(x) ^ ROTR13(x) ^ ROTR22(x).
- function2  output  32  registered Σ1(x) = ROTR6(x) ^ ROTR11(x) ^ ROTR25(x).
- function3  output  32  registered σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- function4  output  32  present only with SHA_SIGMA_LOWER1_EN; registered σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).

## Operation
- ROTRn: 32-bit circular right rotate by n; bit i of result = bit (i+n) mod 32 of x.
- SHRn: logical right shift by n, zero-fill from MSB.
- Results are pure bitwise XOR of three shifted copies; no carries, no arithmetic.
- All functions computed combinationally from x, captured into output registers.
- Every function's rotate/shift amounts are constants; no barrel shifter.
- Priority on each rising edge: rst, then en, then hold.
- rst=1: all outputs <= 32'h0000_0000, regardless of en.
- rst=0, en=1: each output <= its function of current x.
- rst=0, en=0: outputs keep previous value.
- x changes while en=0 have no effect on outputs.

## Timing
- Latency: exactly 1 clock from x/en sampled to output valid.
- Throughput: one new operand per clock when en held high.
- Reset value of every output: 0; applies on first rising edge with rst=1.
- Reset asserted mid-stream clears outputs on that edge; next edge with rst=0, en=1 loads fresh results.
- Simultaneous rst=1 and en=1: reset wins.
- No handshake, no state machine; outputs are plain registers.
- Combinational depth: two 2-input XOR levels per output bit.

## Configuration
- Macro SHA_SIGMA_LOWER1_EN.
- Defined: adds port function4 and its register computing σ1 with same reset/enable/latency rules as other outputs.
- Not defined: function4 port and logic absent; the block provides only function1–function3.

## Test plan
- rst=1 for 2 clocks, en=1, x=32'h0000_3FFF -> all outputs 0 after each reset edge.
- rst=0, en=1, x=32'h0000_3FFF -> one edge later function1=32'h3F07_F3FE, function2=32'h03FF_FF78, function3=32'hF1FF_C780 (function4=32'h1800_600F when macro defined).
- x=32'h0000_0000, en=1 -> all outputs 0; x=32'hFFFF_FFFF -> function1=function2=32'hFFFF_FFFF, function3=32'h1FFF_FFFF.
- After loading x=32'h0000_3FFF, drop en=0, change x to 32'hFFFF_FFFF for 3 clocks -> outputs unchanged (32'h3F07_F3FE / 32'h03FF_FF78 / 32'hF1FF_C780).
- Assert rst=1 together with en=1 while outputs nonzero -> outputs 0 on that edge; release rst with x=32'h0000_3FFF -> correct values one edge later.
- Back-to-back x sequence 32'h0000_3FFF then 32'h0000_0000 with en=1 -> outputs track with 1-clock latency, no bubbles.
